vram_write_scheduler: RTL and testbench

- Queues CPU-originated VRAM writes and replays them into the GPU VRAM write port only while the video timing reports the writable (vblank) window.
- The CPU can therefore issue VRAM writes at any time without corrupting active scan-out.
- Sits between the CPU bus decode (VRAM select and write strobe) and the foreground/background VRAM write inputs of the GPU.
- Single clock domain: clk_12_5875.

---
 rtl/vram_write_scheduler.sv | 153 +++++++++++++++
 tb/tb_vram_write_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_scheduler.sv
// Purpose : queue CPU VRAM writes and replay them into the GPU VRAM write port only inside the writable (vblank) window.
// Latency : 1 cycle minimum from the accepting edge to vram_we; then one entry per clk_12_5875 cycle while writable stays high.
// Backpres: none toward the CPU; a request arriving while full with no drain that cycle is dropped and flagged in sticky overflow.
//
// Ports
//   clk_12_5875     GPU pixel clock, the only clock
//   rst             synchronous active-high reset (pointers, count, overflow)
//   cpu_clk_enable  strobe marking the cycle on which the CPU bus is sampled
//   cpu_write       qualified VRAM write request
//   cpu_address     CPU write address
//   cpu_data        CPU write data
//   writable        high while VRAM may be written (from video timing)
//   vram_we         write strobe to VRAM, combinational: writable && !empty
//   vram_address    head entry address, driven straight from a register
//   vram_data       head entry data, driven straight from a register
//   count           number of queued entries
//   full / empty    derived from count
//   overflow        sticky: a request was dropped
//   clr_overflow    clears overflow (a simultaneous drop wins)
module vram_write_scheduler #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_12_5875,
    input  logic                  rst,
    input  logic                  cpu_clk_enable,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]            cpu_data,
    input  logic                  writable,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]            vram_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            data;
    } entry_t;

    // Entry storage; deliberately has no reset, only the pointers and count do.
    entry_t mem [DEPTH];

    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr_next;

    entry_t cpu_entry;
    entry_t head_q;
    entry_t head_next;

    logic req;
    logic accept;
    logic drain;
    logic drop;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    assign req   = cpu_clk_enable && cpu_write;
    assign drain = writable && !empty;

    // While full, a request is still taken if the head leaves on the same
    // edge: the freed slot is the one the write pointer is sitting on.
    assign accept = req && (!full || drain);
    assign drop   = req && full && !drain;

    assign cpu_entry = '{addr: cpu_address, data: cpu_data};

    // ------------------------------------------------------------------
    // Head register
    // The VRAM address/data outputs are a registered copy of the entry at
    // the read pointer, so they never glitch inside a cycle. The copy is
    // refreshed every edge with the entry that will be at the head after
    // that edge. When that slot is the one being written on the same edge
    // (queue empty, or last entry leaving), the incoming CPU entry is
    // loaded instead, because the array still holds stale contents there.
    // This only feeds the register; vram_we still needs a non-empty count,
    // so no write can reach VRAM in the accepting cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_next = rd_ptr;
        if (drain) begin
            rd_ptr_next = rd_ptr + PTR_WIDTH'(1);
        end
    end

    always_comb begin
        head_next = mem[rd_ptr_next];
        if (accept && (wr_ptr == rd_ptr_next)) begin
            head_next = cpu_entry;
        end
    end

    assign vram_we      = drain;
    assign vram_address = head_q.addr;
    assign vram_data    = head_q.data;

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk_12_5875) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= cpu_entry;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, head copy
    // Pointers are log2(DEPTH) bits and wrap on their own; full/empty come
    // from count so no extra wrap bit is needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count + CNT_WIDTH'(accept) - CNT_WIDTH'(drain);
            head_q <= head_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: fixed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue model.
module tb_vram_write_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = 12;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_12_5875 = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_clk_enable = 1'b0;
    logic          cpu_write = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [7:0]    cpu_data = '0;
    logic          writable = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          vram_we;
    logic [AW-1:0] vram_address;
    logic [7:0]    vram_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    always #5 clk_12_5875 = ~clk_12_5875;

    vram_write_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_12_5875   (clk_12_5875),
        .rst           (rst),
        .cpu_clk_enable(cpu_clk_enable),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_data      (cpu_data),
        .writable      (writable),
        .vram_we       (vram_we),
        .vram_address  (vram_address),
        .vram_data     (vram_data),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an ordered list of pending {addr,data} plus the flag.
    logic [19:0] mq [$];
    bit          m_ovf = 1'b0;
    bit          model_valid = 1'b0;

    // Every VRAM write the DUT issues, in order.
    logic [19:0] dlog [$];

    // DUT outputs captured mid-cycle by do_cycle.
    logic          o_we;
    logic [AW-1:0] o_a;
    logic [7:0]    o_d;
    logic [CW-1:0] o_cnt;
    logic          o_full, o_empty, o_ovf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // One clock cycle: drive inputs, compare against the model at the
    // falling edge, then advance the model at the rising edge.
    task automatic do_cycle(input bit r, input bit en, input bit wr, input logic [AW-1:0] a,
                            input logic [7:0] d, input bit wt, input bit clr);
        bit m_empty, m_full, m_drain, m_acc;
        logic [19:0] h;
        rst = r; cpu_clk_enable = en; cpu_write = wr; cpu_address = a;
        cpu_data = d; writable = wt; clr_overflow = clr;
        @(negedge clk_12_5875);
        o_we = vram_we; o_a = vram_address; o_d = vram_data; o_cnt = count;
        o_full = full; o_empty = empty; o_ovf = overflow;
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == DEPTH);
        m_drain = wt && !m_empty;
        m_acc   = en && wr && (!m_full || m_drain);
        if (model_valid) begin
            check("model_we", vram_we, m_drain);
            check("model_count", count, mq.size());
            check("model_full", full, m_full);
            check("model_empty", empty, m_empty);
            check("model_ovf", overflow, m_ovf);
            if (m_drain) begin
                h = mq[0];
                check("model_addr", vram_address, h[19:8]);
                check("model_data", vram_data, h[7:0]);
            end
        end
        if (vram_we === 1'b1) dlog.push_back({vram_address, vram_data});
        @(posedge clk_12_5875);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            model_valid = 1'b1;
        end else begin
            if (m_drain) void'(mq.pop_front());
            if (m_acc) mq.push_back({a, d});
            if (en && wr && !m_acc) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit wt);
        do_cycle(1'b0, 1'b0, 1'b0, '0, '0, wt, 1'b0);
    endtask

    task automatic wr_cycle(input logic [AW-1:0] a, input logic [7:0] d, input bit wt);
        do_cycle(1'b0, 1'b1, 1'b1, a, d, wt, 1'b0);
    endtask

    task automatic check_log(input string nm, input int idx, input logic [AW-1:0] ea, input logic [7:0] ed);
        logic [19:0] e;
        e = (idx < dlog.size()) ? dlog[idx] : 20'hxxxxx;
        check($sformatf("%s_addr%0d", nm, idx), e[19:8], ea);
        check($sformatf("%s_data%0d", nm, idx), e[7:0], ed);
    endtask

    typedef struct {
        bit r, en, wr; logic [AW-1:0] a; logic [7:0] d; bit wt, clr, chk;
        bit e_we; logic [AW-1:0] e_a; logic [7:0] e_d; int e_cnt; bit e_full, e_empty, e_ovf;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit en, input bit wr, input logic [AW-1:0] a,
                                input logic [7:0] d, input bit wt, input bit clr, input bit chk,
                                input bit we, input logic [AW-1:0] ea, input logic [7:0] ed,
                                input int cnt, input bit fl, input bit em, input bit ov);
        vec_t v;
        v.r = r; v.en = en; v.wr = wr; v.a = a; v.d = d; v.wt = wt; v.clr = clr; v.chk = chk;
        v.e_we = we; v.e_a = ea; v.e_d = ed; v.e_cnt = cnt; v.e_full = fl; v.e_empty = em; v.e_ovf = ov;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        vec_t v;
        bit wt_r;

        //              r en wr addr    data   wt clr chk we  e_addr  e_data cnt fl em ov
        tbl[0]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0, 12'h000, 8'h00, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 1, 12'h010, 8'hA1, 0, 0, 1, 0, 12'h000, 8'h00, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 1, 12'h7AA, 8'hEE, 0, 0, 1, 0, 12'h000, 8'h00, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 12'h011, 8'hB2, 0, 0, 1, 0, 12'h000, 8'h00, 1, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 12'h3FF, 8'hC3, 0, 0, 1, 0, 12'h000, 8'h00, 2, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0, 12'h000, 8'h00, 3, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 1, 12'h010, 8'hA1, 3, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 1, 12'h011, 8'hB2, 2, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 1, 12'h3FF, 8'hC3, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 0, 12'h000, 8'h00, 0, 0, 1, 0);
        tbl[11] = mk(0, 1, 1, 12'h020, 8'h55, 1, 0, 1, 0, 12'h000, 8'h00, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 1, 12'h020, 8'h55, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 0, 12'h000, 8'h00, 0, 0, 1, 0);

        // Reset, queued writes outside the window, replay, single-write latency.
        for (int i = 0; i < 14; i++) begin
            v = tbl[i];
            do_cycle(v.r, v.en, v.wr, v.a, v.d, v.wt, v.clr);
            if (v.chk) begin
                check($sformatf("vec%0d_we", i), o_we, v.e_we);
                check($sformatf("vec%0d_count", i), o_cnt, v.e_cnt);
                check($sformatf("vec%0d_full", i), o_full, v.e_full);
                check($sformatf("vec%0d_empty", i), o_empty, v.e_empty);
                check($sformatf("vec%0d_ovf", i), o_ovf, v.e_ovf);
                if (v.e_we) begin
                    check($sformatf("vec%0d_addr", i), o_a, v.e_a);
                    check($sformatf("vec%0d_data", i), o_d, v.e_d);
                end
            end
        end

        // 17 writes outside the window: the 17th is dropped.
        dlog.delete();
        for (int i = 0; i < 17; i++) begin
            wr_cycle(12'h200 + 12'(i), 8'(i), 1'b0);
            if (i == 15) check("fill_full16", full, 1);
        end
        check("fill_count", count, 16);
        check("fill_ovf_set", overflow, 1);
        do_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);
        // Drop and clear on the same edge: the drop wins.
        do_cycle(1'b0, 1'b1, 1'b1, 12'h2FF, 8'hFF, 1'b0, 1'b1);
        check("ovf_set_wins", overflow, 1);
        check("ovf_set_wins_count", count, 16);
        do_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("ovf_cleared2", overflow, 0);

        // Full queue, window open, write on the same cycle: accepted.
        wr_cycle(12'h100, 8'h77, 1'b1);
        check("full_drain_count", count, 16);
        check("full_drain_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) idle(1'b1);
        idle(1'b0);
        check("full_drain_empty", empty, 1);
        check("full_drain_len", dlog.size(), 17);
        for (int i = 0; i < 16; i++) check_log("fill", i, 12'h200 + 12'(i), 8'(i));
        check_log("fill", 16, 12'h100, 8'h77);

        // 10 queued, 4-cycle window, then the rest in the next window.
        dlog.delete();
        for (int i = 0; i < 10; i++) wr_cycle(12'h300 + 12'(i), 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        check("win_we_low", o_we, 0);
        check("win_count6", count, 6);
        check("win_len4", dlog.size(), 4);
        for (int i = 0; i < 6; i++) idle(1'b1);
        idle(1'b0);
        check("win_empty", empty, 1);
        check("win_len10", dlog.size(), 10);
        for (int i = 0; i < 10; i++) check_log("win", i, 12'h300 + 12'(i), 8'h40 + 8'(i));

        // Reset mid-drain with 5 left and overflow set.
        for (int i = 0; i < 17; i++) wr_cycle(12'h400 + 12'(i), 8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 11; i++) idle(1'b1);
        check("rst_pre_count", count, 5);
        check("rst_pre_ovf", overflow, 1);
        do_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        check("rst_we", vram_we, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        dlog.delete();
        wr_cycle(12'h555, 8'h5A, 1'b1);
        wr_cycle(12'h556, 8'h5B, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("post_rst_len", dlog.size(), 2);
        check_log("post_rst", 0, 12'h555, 8'h5A);
        check_log("post_rst", 1, 12'h556, 8'h5B);

        // Randomized traffic; windows close for longer than they open so
        // the queue regularly reaches full.
        wt_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (wt_r ? ($urandom_range(3) == 0) : ($urandom_range(23) == 0)) wt_r = !wt_r;
            do_cycle($urandom_range(299) == 0, $urandom_range(1) == 1, $urandom_range(3) != 0,
                     AW'($urandom), 8'($urandom), wt_r, $urandom_range(19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
